// File: rtl/cpu_ms_pkg.sv
// Shared types and constants for the per-CPU data source of the multisim example.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package cpu_ms_pkg;

    localparam int          DATA_W    = 64;
    localparam int          IDX_W     = 32;
    localparam logic [15:0] LFSR_SEED = 16'hACE1;

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        SEND,
        GAP,
        DONE
    } state_t;

    // A Fibonacci LFSR locks up at zero, so a zero seed is replaced by 1.
    function automatic logic [15:0] lfsr_seed(input logic [15:0] idx_lo);
        logic [15:0] s;
        s = idx_lo ^ LFSR_SEED;
        return (s == 16'h0000) ? 16'h0001 : s;
    endfunction

endpackage

// File: rtl/lfsr16.sv
// 16-bit Fibonacci LFSR (x^16+x^14+x^13+x^11+1), right-shifting, feedback into bit 15.
// Latency: value reflects an advance one cycle after it is requested.
// Backpressure: holds its value whenever advance is low.
module lfsr16 (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] seed,
    input  logic        advance,
    output logic [15:0] value
);

    logic [15:0] r_lfsr;
    logic        w_fb;

    // Taps 16,14,13,11 land on bits 0,2,3,5 in the right-shift form.
    assign w_fb  = r_lfsr[0] ^ r_lfsr[2] ^ r_lfsr[3] ^ r_lfsr[5];
    assign value = r_lfsr;

    // Load the seed in reset, step once per advance request.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_lfsr <= seed;
        end else if (advance) begin
            r_lfsr <= {w_fb, r_lfsr[15:1]};
        end
    end

endmodule

// File: rtl/cpu_data_source.sv
// Emits NB_TRANSACTIONS words {cpu_index, cnt} on a valid/ready stream with optional LFSR idle gaps.
// Latency: first word valid 2 cycles after reset release; back-to-back words one per cycle.
// Backpressure: data_rdy low stalls with data_vld/data held; counter and LFSR freeze.
module cpu_data_source
    import cpu_ms_pkg::*;
#(
    parameter int unsigned NB_TRANSACTIONS = 1000,
    parameter bit          GAP_EN          = 1'b1,
    parameter int unsigned MAX_GAP_LOG2    = 3
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic [IDX_W-1:0]  cpu_index,
    input  logic              data_rdy,
    output logic              data_vld,
    output logic [DATA_W-1:0] data,
    output logic              transactions_done
);

    localparam logic [31:0]             NB_LAST = NB_TRANSACTIONS;
    localparam logic [MAX_GAP_LOG2-1:0] GAP_ONE = MAX_GAP_LOG2'(1);

    state_t                  r_state,   w_state_nxt;
    logic [31:0]             r_cnt,     w_cnt_nxt;
    logic [MAX_GAP_LOG2-1:0] r_gap_cnt, w_gap_cnt_nxt;
    logic                    r_vld,     w_vld_nxt;
    logic [DATA_W-1:0]       r_data,    w_data_nxt;
    logic                    r_done,    w_done_nxt;

    logic                    w_xfer;
    logic [31:0]             w_cnt_inc;
    logic                    w_last;
    logic [15:0]             w_seed;
    logic [15:0]             w_lfsr;
    logic [MAX_GAP_LOG2-1:0] w_gap;
    logic                    w_unused_lfsr;

    assign w_xfer        = r_vld && data_rdy;
    assign w_cnt_inc     = r_cnt + 32'd1;
    assign w_last        = (w_cnt_inc == NB_LAST);
    assign w_seed        = lfsr_seed(cpu_index[15:0]);
    assign w_gap         = w_lfsr[MAX_GAP_LOG2-1:0];
    assign w_unused_lfsr = ^w_lfsr[15:MAX_GAP_LOG2];

    // Gap source steps once per accepted word; the gap uses the pre-step value.
    lfsr16 u_lfsr (
        .clk     (clk),
        .rst_n   (rst_n),
        .seed    (w_seed),
        .advance (w_xfer),
        .value   (w_lfsr)
    );

    // Next-state and next registered-output values.
    always_comb begin
        w_state_nxt   = r_state;
        w_cnt_nxt     = r_cnt;
        w_gap_cnt_nxt = r_gap_cnt;
        w_vld_nxt     = r_vld;
        w_data_nxt    = r_data;
        w_done_nxt    = r_done;
        case (r_state)
            IDLE: begin
                w_state_nxt = LOAD;
            end
            LOAD: begin
                w_vld_nxt   = 1'b1;
                w_data_nxt  = {cpu_index, r_cnt};
                w_state_nxt = SEND;
            end
            SEND: begin
                if (w_xfer) begin
                    w_cnt_nxt = w_cnt_inc;
                    if (w_last) begin
                        w_vld_nxt   = 1'b0;
                        w_done_nxt  = 1'b1;
                        w_state_nxt = DONE;
                    end else if (GAP_EN && (w_gap != '0)) begin
                        // The LOAD cycle is itself idle, so GAP only covers g-1 cycles.
                        w_vld_nxt     = 1'b0;
                        w_gap_cnt_nxt = w_gap - GAP_ONE;
                        w_state_nxt   = (w_gap == GAP_ONE) ? LOAD : GAP;
                    end else begin
                        w_data_nxt = {cpu_index, w_cnt_inc};
                    end
                end
            end
            GAP: begin
                w_gap_cnt_nxt = r_gap_cnt - GAP_ONE;
                if (r_gap_cnt == GAP_ONE) begin
                    w_state_nxt = LOAD;
                end
            end
            DONE: begin
                w_vld_nxt  = 1'b0;
                w_done_nxt = 1'b1;
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset drops any in-flight word.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_state   <= IDLE;
            r_cnt     <= '0;
            r_gap_cnt <= '0;
            r_vld     <= 1'b0;
            r_data    <= '0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_cnt     <= w_cnt_nxt;
            r_gap_cnt <= w_gap_cnt_nxt;
            r_vld     <= w_vld_nxt;
            r_data    <= w_data_nxt;
            r_done    <= w_done_nxt;
        end
    end

    assign data_vld          = r_vld;
    assign data              = r_data;
    assign transactions_done = r_done;

endmodule

// File: tb/tb_cpu_data_source.sv
module tb_cpu_data_source;

    logic clk = 1'b0;
    logic rst_n;
    logic rdy;
    int   n_tests = 0;
    int   n_fail  = 0;

    always #5 clk = ~clk;

    // Back-to-back instance: cpu 3, 4 words, no gaps.
    logic        b_vld, b_done;
    logic [63:0] b_data;
    cpu_data_source #(.NB_TRANSACTIONS(4), .GAP_EN(1'b0), .MAX_GAP_LOG2(3)) u_b2b (
        .clk(clk), .rst_n(rst_n), .cpu_index(32'd3), .data_rdy(rdy),
        .data_vld(b_vld), .data(b_data), .transactions_done(b_done));

    // Gapped instances: cpu 0 and cpu 1, 16 words each.
    logic        g_vld  [2];
    logic        g_done [2];
    logic [63:0] g_data [2];
    cpu_data_source #(.NB_TRANSACTIONS(16), .GAP_EN(1'b1), .MAX_GAP_LOG2(3)) u_gap0 (
        .clk(clk), .rst_n(rst_n), .cpu_index(32'd0), .data_rdy(rdy),
        .data_vld(g_vld[0]), .data(g_data[0]), .transactions_done(g_done[0]));
    cpu_data_source #(.NB_TRANSACTIONS(16), .GAP_EN(1'b1), .MAX_GAP_LOG2(3)) u_gap1 (
        .clk(clk), .rst_n(rst_n), .cpu_index(32'd1), .data_rdy(rdy),
        .data_vld(g_vld[1]), .data(g_data[1]), .transactions_done(g_done[1]));

    // Mid-run reset instance: cpu 5, 8 words, gaps on.
    logic        m_vld, m_done;
    logic [63:0] m_data;
    cpu_data_source #(.NB_TRANSACTIONS(8), .GAP_EN(1'b1), .MAX_GAP_LOG2(3)) u_mid (
        .clk(clk), .rst_n(rst_n), .cpu_index(32'd5), .data_rdy(rdy),
        .data_vld(m_vld), .data(m_data), .transactions_done(m_done));

    // Reference model: seed and one polynomial step of x^16+x^14+x^13+x^11+1.
    function automatic logic [15:0] model_seed(input int unsigned idx);
        int unsigned s;
        s = (idx & 32'hFFFF) ^ 32'hACE1;
        if (s == 0) s = 1;
        return 16'(s);
    endfunction

    function automatic logic [15:0] model_step(input logic [15:0] l);
        int unsigned v;
        int unsigned b;
        v = l;
        b = (v ^ (v >> 2) ^ (v >> 3) ^ (v >> 5)) & 1;
        return 16'((v >> 1) | (b << 15));
    endfunction

    task automatic hold_reset();
        rst_n = 1'b0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        rdy   = 1'b1;
        repeat (2) @(negedge clk);
        n_tests++; if (b_vld !== 1'b0) begin n_fail++; $display("FAIL reset_vld: got %b want 0", b_vld); end
        n_tests++; if (b_data !== 64'd0) begin n_fail++; $display("FAIL reset_data: got %h want 0", b_data); end
        n_tests++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", b_done); end
        n_tests++; if (g_vld[0] !== 1'b0 || g_done[1] !== 1'b0) begin n_fail++; $display("FAIL reset_gap: got vld=%b done=%b want 0 0", g_vld[0], g_done[1]); end
        rst_n = 1'b1;
        @(negedge clk);
        n_tests++; if (b_vld !== 1'b0) begin n_fail++; $display("FAIL first_cycle_vld: got %b want 0", b_vld); end
        @(negedge clk);
        n_tests++; if (b_vld !== 1'b1) begin n_fail++; $display("FAIL second_cycle_vld: got %b want 1", b_vld); end
        n_tests++; if (b_data !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL second_cycle_data: got %h want %h", b_data, {32'd3, 32'd0}); end
    endtask

    task automatic test_back_to_back();
        rdy = 1'b1;
        hold_reset();
        repeat (2) @(negedge clk);
        for (int k = 0; k < 4; k++) begin
            n_tests++; if (b_vld !== 1'b1) begin n_fail++; $display("FAIL b2b_vld[%0d]: got %b want 1", k, b_vld); end
            n_tests++; if (b_data !== {32'd3, 32'(k)}) begin n_fail++; $display("FAIL b2b_data[%0d]: got %h want %h", k, b_data, {32'd3, 32'(k)}); end
            n_tests++; if (b_done !== 1'b0) begin n_fail++; $display("FAIL b2b_early_done[%0d]: got %b want 0", k, b_done); end
            @(negedge clk);
        end
        n_tests++; if (b_vld !== 1'b0) begin n_fail++; $display("FAIL b2b_vld_after: got %b want 0", b_vld); end
        n_tests++; if (b_done !== 1'b1) begin n_fail++; $display("FAIL b2b_done: got %b want 1", b_done); end
    endtask

    task automatic test_backpressure();
        rdy = 1'b0;
        hold_reset();
        repeat (2) @(negedge clk);
        for (int c = 0; c < 5; c++) begin
            n_tests++; if (b_vld !== 1'b1) begin n_fail++; $display("FAIL bp_vld[%0d]: got %b want 1", c, b_vld); end
            n_tests++; if (b_data !== {32'd3, 32'd0}) begin n_fail++; $display("FAIL bp_data[%0d]: got %h want %h", c, b_data, {32'd3, 32'd0}); end
            @(negedge clk);
        end
        rdy = 1'b1;
        @(negedge clk);
        n_tests++; if (b_data !== {32'd3, 32'd1} || b_vld !== 1'b1) begin n_fail++; $display("FAIL bp_release: got vld=%b data=%h want 1 %h", b_vld, b_data, {32'd3, 32'd1}); end
    endtask

    task automatic test_gap_sequence();
        int          xfers [2];
        int          idle  [2];
        int          exp_gap [2];
        logic [15:0] lf    [2];
        int          seen  [2][$];
        int          diff;
        for (int d = 0; d < 2; d++) begin
            xfers[d] = 0; idle[d] = 0; exp_gap[d] = 0; lf[d] = model_seed(d);
            seen[d].delete();
        end
        rdy = 1'b1;
        hold_reset();
        for (int c = 0; c < 400; c++) begin
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                if (g_vld[d]) begin
                    n_tests++; if (xfers[d] >= 16) begin n_fail++; $display("FAIL gap_extra[%0d]: got transfer %0d want at most 16", d, xfers[d] + 1); end
                    n_tests++; if (g_data[d] !== {32'(d), 32'(xfers[d])}) begin n_fail++; $display("FAIL gap_data[%0d]: got %h want %h", d, g_data[d], {32'(d), 32'(xfers[d])}); end
                    if (xfers[d] > 0) begin
                        seen[d].push_back(idle[d]);
                        n_tests++; if (idle[d] != exp_gap[d]) begin n_fail++; $display("FAIL gap_idle[%0d] word %0d: got %0d want %0d", d, xfers[d], idle[d], exp_gap[d]); end
                        n_tests++; if (idle[d] > 7) begin n_fail++; $display("FAIL gap_max[%0d]: got %0d want <=7", d, idle[d]); end
                    end
                    exp_gap[d] = int'(lf[d][2:0]);
                    lf[d]      = model_step(lf[d]);
                    xfers[d]++;
                    idle[d] = 0;
                end else if (xfers[d] > 0) begin
                    idle[d]++;
                end
            end
            if (xfers[0] >= 16 && xfers[1] >= 16) break;
        end
        @(negedge clk);
        diff = 0;
        for (int d = 0; d < 2; d++) begin
            n_tests++; if (xfers[d] != 16) begin n_fail++; $display("FAIL gap_count[%0d]: got %0d want 16", d, xfers[d]); end
            n_tests++; if (g_done[d] !== 1'b1 || g_vld[d] !== 1'b0) begin n_fail++; $display("FAIL gap_done[%0d]: got done=%b vld=%b want 1 0", d, g_done[d], g_vld[d]); end
        end
        for (int i = 0; i < seen[0].size() && i < seen[1].size(); i++)
            if (seen[0][i] != seen[1][i]) diff++;
        n_tests++; if (diff == 0) begin n_fail++; $display("FAIL gap_differ: got %0d differing gaps want >0", diff); end
    endtask

    task automatic test_done_sticky();
        for (int c = 0; c < 50; c++) begin
            rdy = 1'($urandom_range(0, 1));
            @(negedge clk);
            for (int d = 0; d < 2; d++) begin
                n_tests++; if (g_vld[d] !== 1'b0 || g_done[d] !== 1'b1) begin n_fail++; $display("FAIL sticky[%0d] cycle %0d: got vld=%b done=%b want 0 1", d, c, g_vld[d], g_done[d]); end
            end
            n_tests++; if (b_vld !== 1'b0 || b_done !== 1'b1) begin n_fail++; $display("FAIL sticky_b2b cycle %0d: got vld=%b done=%b want 0 1", c, b_vld, b_done); end
        end
    endtask

    task automatic test_reset_mid();
        int k;
        rdy = 1'b0;
        hold_reset();
        k = 0;
        for (int c = 0; c < 200 && k < 2; c++) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            if (m_vld && rdy) begin
                n_tests++; if (m_data !== {32'd5, 32'(k)}) begin n_fail++; $display("FAIL mid_pre_data[%0d]: got %h want %h", k, m_data, {32'd5, 32'(k)}); end
                k++;
            end
        end
        n_tests++; if (k != 2) begin n_fail++; $display("FAIL mid_pre_count: got %0d want 2", k); end
        @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        n_tests++; if (m_vld !== 1'b0 || m_data !== 64'd0 || m_done !== 1'b0) begin n_fail++; $display("FAIL mid_clear: got vld=%b data=%h done=%b want 0 0 0", m_vld, m_data, m_done); end
        rst_n = 1'b1;
        k = 0;
        for (int c = 0; c < 400 && k < 8; c++) begin
            @(negedge clk);
            rdy = 1'($urandom_range(0, 1));
            if (m_vld && rdy) begin
                n_tests++; if (m_data !== {32'd5, 32'(k)}) begin n_fail++; $display("FAIL mid_data[%0d]: got %h want %h", k, m_data, {32'd5, 32'(k)}); end
                n_tests++; if (m_done !== 1'b0) begin n_fail++; $display("FAIL mid_early_done[%0d]: got %b want 0", k, m_done); end
                k++;
            end
        end
        @(negedge clk);
        n_tests++; if (k != 8) begin n_fail++; $display("FAIL mid_count: got %0d want 8", k); end
        n_tests++; if (m_done !== 1'b1 || m_vld !== 1'b0) begin n_fail++; $display("FAIL mid_done: got done=%b vld=%b want 1 0", m_done, m_vld); end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
        $fatal(1);
    end

    initial begin
        rst_n = 1'b0;
        rdy   = 1'b0;
        test_reset();
        test_back_to_back();
        test_backpressure();
        test_gap_sequence();
        test_done_sticky();
        test_reset_mid();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
